ubvcska_sum_accumulator: RTL and testbench
==========================================

// Module: ubvcska_sum_accumulator
// PURPOSE
//  Downstream consumer of the 15b+12b variable-block carry-skip adder (UBVCSkA_14_0_11_0).
//  Registers each 16-bit sum S, accumulates BLOCK_LEN consecutive sums into a widened total, then presents it.
//  Valid/ready on both sides; sits between the combinational adder and the block-result bus.
// PARAMETERS
//  SUM_W      16  width of incoming adder sum (fixed by 15b+12b operands)
//  BLOCK_LEN  8   sums per block; power of two, 2..256
//  ACC_W      SUM_W+$clog2(BLOCK_LEN)  accumulator/result width (19 at defaults); never overflows
// PORTS
//  CLK        in   1      rising-edge clock, sole clock
//  RSTn       in   1      reset, synchronous, active-low
//  IN_VALID   in   1      S_IN carries a valid adder sum
//  IN_READY   out  1      block can accept S_IN this cycle
//  S_IN       in   SUM_W  adder sum S[15:0], unsigned
//  CLR        in   1      abort current block, discard partial total
//  OUT_VALID  out  1      OUT_ACC holds a completed block total
//  OUT_READY  in   1      consumer takes OUT_ACC
//  OUT_ACC    out  ACC_W  sum of BLOCK_LEN accepted S_IN values
//  OUT_LAST   out  1      pulse 1 cycle: block accepted by consumer
// BEHAVIOUR
//  Reset (RSTn=0 at edge): state=IDLE, acc=0, cnt=0, OUT_VALID=0, OUT_ACC=0, OUT_LAST=0; IN_READY=0 during reset cycle.
//  Reset mid-block or mid-HOLD discards everything; no output produced for that block.
//  Handshake: transfer iff VALID&&READY at rising edge; VALID never depends on READY.
//  OUT_VALID, once high, stays high with OUT_ACC stable until OUT_READY sampled high.
//  IN_READY = (state!=HOLD) || OUT_READY (combinational pass-through: a new sum may be taken in the hold-release cycle).
//  FSM:
//   IDLE : cnt=0, acc=0. Input transfer -> acc=S_IN, cnt=1, ->ACCUM (or ->HOLD if BLOCK_LEN==1 not allowed; min 2).
//   ACCUM: input transfer -> acc+=S_IN, cnt+=1; when cnt==BLOCK_LEN-1 at transfer: OUT_ACC<=acc+S_IN,
//          OUT_VALID<=1, acc<=0, cnt<=0, ->HOLD.
//   HOLD : output waits. OUT_READY=1 -> OUT_VALID<=0, OUT_LAST pulses next cycle; if an input transfer
//          happens in same cycle, it starts the next block (acc=S_IN, cnt=1, ->ACCUM), else ->IDLE.
//  Latency: OUT_VALID rises the cycle after the BLOCK_LEN-th input transfer.
//  Arithmetic: unsigned, S_IN zero-extended to ACC_W; max total BLOCK_LEN*(2^SUM_W-1) fits ACC_W exactly.
//  CLR (priority below RSTn, above everything else): IDLE/ACCUM -> acc=0, cnt=0, ->IDLE; input offered
//   that cycle is NOT accepted (IN_READY forced 0 while CLR=1). In HOLD, CLR does not drop the pending
//   output (already committed); it only blocks input acceptance.
//  No input accepted while CLR=1 or RSTn=0. OUT_LAST never asserted without a preceding output transfer.
// STRUCTURE
//  Shared package ubvcska_pkg: SUM_W localparam (16), state enum {IDLE,ACCUM,HOLD}, acc width function.
//  One sub-module: ubvcska_acc_outreg -- ACC_W-wide valid/ready holding register for OUT_ACC/OUT_VALID/OUT_LAST.
//  Accumulation add is a plain behavioural adder; the carry-skip adder itself stays upstream, unmodified.
// TESTING
//  1 Reset: RSTn=0 2 cycles mid-ACCUM (cnt=3) -> all outputs 0, next block starts from acc=0, cnt=0.
//  2 Max: 8 sums of 0x8FFE (32767+4095), OUT_READY=1 -> OUT_ACC=0x47FF0, OUT_VALID 1 cycle after 8th transfer.
//  3 Backpressure: OUT_READY=0 for 5 cycles in HOLD -> OUT_ACC stable, IN_READY=0, no input lost/accepted.
//  4 Back-to-back: 9th sum offered with OUT_READY=1 in HOLD -> accepted same cycle, OUT_LAST pulses, next acc=9th sum.
//  5 CLR at cnt=5 with IN_VALID=1 -> input not taken, state IDLE; next 8 sums of 1 give OUT_ACC=8.
//  6 Random IN_VALID/OUT_READY, 10k sums vs model sum(X+Y) -> every OUT_ACC matches, block count exact.

Source files
------------

// File: rtl/ubvcska_pkg.sv
// Shared definitions for the carry-skip adder sum accumulator.
// Sum width is fixed by the 15b+12b adder operands.
package ubvcska_pkg;

    localparam int SUM_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Width that holds block_len worst-case sums without overflow.
    function automatic int acc_width(input int sum_w, input int block_len);
        return sum_w + $clog2(block_len);
    endfunction

endpackage

// File: rtl/ubvcska_acc_outreg.sv
// Valid/ready holding register for a completed block total.
// The total stays stable while valid is high; last pulses once after each handoff.
module ubvcska_acc_outreg #(
    parameter int ACC_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ACC_W-1:0] load_acc,
    input  logic             ready,
    output logic             valid,
    output logic [ACC_W-1:0] acc,
    output logic             last
);

    logic take;
    assign take = valid && ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            acc   <= '0;
            last  <= 1'b0;
        end else begin
            last <= take;
            if (load) begin
                valid <= 1'b1;
                acc   <= load_acc;
            end else if (take) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ubvcska_sum_accumulator.sv
// Accumulates BLOCK_LEN consecutive adder sums into a widened total and
// presents it on a valid/ready output; one block may be held while the next starts.
//
// state | meaning
// IDLE  | no partial block, acc=0, cnt=0
// ACCUM | partial block in progress
// HOLD  | completed total waiting for the consumer
module ubvcska_sum_accumulator
    import ubvcska_pkg::*;
#(
    parameter int BLOCK_LEN = 8,
    parameter int ACC_W     = acc_width(SUM_W, BLOCK_LEN)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [SUM_W-1:0] S_IN,
    input  logic             CLR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] OUT_ACC,
    output logic             OUT_LAST
);

    localparam int CNT_W = $clog2(BLOCK_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ACC_W-1:0] s_ext;
    logic [ACC_W-1:0] sum;
    logic             in_xfer;
    logic             load;

    // Ready passes OUT_READY straight through so the hold-release cycle can take a sum.
    assign IN_READY = RSTn && !CLR && ((state != HOLD) || OUT_READY);
    assign in_xfer  = IN_VALID && IN_READY;
    assign s_ext    = ACC_W'(S_IN);
    assign sum      = acc + s_ext;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (CLR) begin
                    acc_nxt = '0;
                    cnt_nxt = '0;
                end else if (in_xfer) begin
                    acc_nxt   = s_ext;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (CLR) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (in_xfer) begin
                    if (cnt == LAST_CNT) begin
                        load      = 1'b1;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // CLR cannot retract a committed total; it only blocks input via IN_READY.
                if (OUT_READY) begin
                    if (in_xfer) begin
                        acc_nxt   = s_ext;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ACCUM;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    ubvcska_acc_outreg #(
        .ACC_W(ACC_W)
    ) u_outreg (
        .clk      (CLK),
        .rst_n    (RSTn),
        .load     (load),
        .load_acc (sum),
        .ready    (OUT_READY),
        .valid    (OUT_VALID),
        .acc      (OUT_ACC),
        .last     (OUT_LAST)
    );

endmodule

// File: tb/tb_ubvcska_sum_accumulator.sv
// Directed and randomized checks of the sum accumulator at BLOCK_LEN=8.
module tb_ubvcska_sum_accumulator;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] S_IN;
    logic        CLR;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [18:0] OUT_ACC;
    logic        OUT_LAST;

    int tests = 0;
    int fails = 0;

    ubvcska_sum_accumulator #(.BLOCK_LEN(8)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .S_IN      (S_IN),
        .CLR       (CLR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_ACC   (OUT_ACC),
        .OUT_LAST  (OUT_LAST)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one sum that must be accepted at the next edge.
    task automatic send(input logic [15:0] v);
        IN_VALID = 1'b1;
        S_IN     = v;
        #1;
        chk("send_in_ready", {31'd0, IN_READY}, 32'd1);
        tick();
        IN_VALID = 1'b0;
    endtask

    logic [18:0] exp_q[$];
    logic [18:0] run_sum;
    logic [18:0] front;
    int          run_n, accepted, blocks_out, lasts, cycles;
    logic        in_x, out_x;

    initial begin
        RSTn = 1'b0; IN_VALID = 1'b0; S_IN = '0; CLR = 1'b0; OUT_READY = 1'b0;
        tick();
        chk("rst_in_ready",  {31'd0, IN_READY},  32'd0);
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_out_acc",   {13'd0, OUT_ACC},   32'd0);
        chk("rst_out_last",  {31'd0, OUT_LAST},  32'd0);
        tick();
        RSTn = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);

        // Reset mid-block discards the partial total
        for (int i = 0; i < 3; i++) send(16'd5);
        RSTn = 1'b0;
        tick(); tick();
        chk("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("midrst_out_acc",   {13'd0, OUT_ACC},   32'd0);
        RSTn = 1'b1;
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) send(16'd2);
        chk("midrst_block_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("midrst_block_acc",   {13'd0, OUT_ACC},   32'd16);
        tick();

        // Worst-case sums; valid appears right after the 8th transfer
        for (int i = 0; i < 8; i++) begin
            send(16'h8FFE);
            chk("max_valid_timing", {31'd0, OUT_VALID}, (i == 7) ? 32'd1 : 32'd0);
        end
        chk("max_acc", {13'd0, OUT_ACC}, 32'h47FF0);
        tick();
        chk("max_released", {31'd0, OUT_VALID}, 32'd0);
        chk("max_last",     {31'd0, OUT_LAST},  32'd1);
        tick();
        chk("max_last_pulse", {31'd0, OUT_LAST}, 32'd0);

        // Backpressure: total held, input refused
        OUT_READY = 1'b0;
        for (int i = 0; i < 8; i++) send(16'(i + 1));
        IN_VALID = 1'b1;
        S_IN     = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready",  {31'd0, IN_READY},  32'd0);
            chk("bp_out_valid", {31'd0, OUT_VALID}, 32'd1);
            chk("bp_out_acc",   {13'd0, OUT_ACC},   32'd36);
            chk("bp_out_last",  {31'd0, OUT_LAST},  32'd0);
            tick();
        end

        // Back-to-back: sum taken in the release cycle starts the next block
        OUT_READY = 1'b1;
        #1;
        chk("b2b_in_ready", {31'd0, IN_READY}, 32'd1);
        tick();
        IN_VALID = 1'b0;
        chk("b2b_released", {31'd0, OUT_VALID}, 32'd0);
        chk("b2b_last",     {31'd0, OUT_LAST},  32'd1);
        for (int i = 0; i < 7; i++) send(16'd1);
        chk("b2b_next_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("b2b_next_acc",   {13'd0, OUT_ACC},   32'h123B);
        tick();

        // CLR mid-block drops the partial total and refuses the offered sum
        for (int i = 0; i < 5; i++) send(16'd100);
        CLR = 1'b1; IN_VALID = 1'b1; S_IN = 16'd100;
        #1;
        chk("clr_in_ready", {31'd0, IN_READY}, 32'd0);
        tick();
        CLR = 1'b0; IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd1);
        chk("clr_acc", {13'd0, OUT_ACC}, 32'd8);
        // CLR in HOLD keeps the committed output
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("clr_hold_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("clr_hold_acc",   {13'd0, OUT_ACC},   32'd8);
        OUT_READY = 1'b1;
        tick();
        chk("clr_hold_released", {31'd0, OUT_VALID}, 32'd0);
        tick();

        // Random handshakes against a running-sum model
        run_sum = '0; run_n = 0; accepted = 0; blocks_out = 0; lasts = 0; cycles = 0;
        IN_VALID = 1'b0;
        while (accepted < 10000 && cycles < 60000) begin
            if (OUT_LAST) lasts++;
            if (!IN_VALID || IN_READY) begin
                IN_VALID = ($urandom_range(0, 3) != 0);
                S_IN = 16'($urandom_range(0, 32767) + $urandom_range(0, 4095));
            end
            OUT_READY = ($urandom_range(0, 2) != 0);
            #1;
            in_x  = IN_VALID && IN_READY;
            out_x = OUT_VALID && OUT_READY;
            if (out_x) begin
                chk("rand_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                front = (exp_q.size() != 0) ? exp_q.pop_front() : 19'd0;
                chk("rand_out_acc", {13'd0, OUT_ACC}, {13'd0, front});
                blocks_out++;
            end
            if (in_x) begin
                accepted++;
                run_sum = run_sum + 19'(S_IN);
                run_n++;
                if (run_n == 8) begin
                    exp_q.push_back(run_sum);
                    run_sum = '0;
                    run_n = 0;
                end
            end
            tick();
            if (in_x) IN_VALID = 1'b0;
            cycles++;
        end
        chk("rand_budget", {31'd0, accepted == 10000}, 32'd1);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (OUT_LAST) lasts++;
            #1;
            if (OUT_VALID) begin
                chk("drain_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                front = (exp_q.size() != 0) ? exp_q.pop_front() : 19'd0;
                chk("drain_out_acc", {13'd0, OUT_ACC}, {13'd0, front});
                blocks_out++;
            end
            tick();
        end
        chk("rand_block_count", blocks_out, 32'd1250);
        chk("rand_q_empty",     exp_q.size(), 32'd0);
        chk("rand_last_count",  lasts, 32'd1250);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
